// File: rtl/fifo.sv
// Single-clock synchronous FIFO, 2**ad_w entries of d_w bits, registered read data.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fifo #(
    parameter int d_w  = 8,
    parameter int ad_w = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           write,
    input  logic           read,
    output logic           full,
    output logic           empty,
    input  logic [d_w-1:0] data_in,
    output logic [d_w-1:0] data_out
);

    localparam int unsigned DEPTH = 2 ** ad_w;

    logic [d_w-1:0] mem_q [DEPTH];
    logic [ad_w:0]  wptr_q, wptr_d;
    logic [ad_w:0]  rptr_q, rptr_d;
    logic [d_w-1:0] dout_q, dout_d;
    logic           wr_en, rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ad_w-1:0] == rptr_q[ad_w-1:0]) && (wptr_q[ad_w] != rptr_q[ad_w]);

    // Both requests are qualified by flags from before the edge; no write-to-read bypass.
    assign wr_en = write && !full;
    assign rd_en = read && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        dout_d = dout_q;
        if (wr_en) begin
            wptr_d = wptr_q + (ad_w + 1)'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + (ad_w + 1)'(1);
            dout_d = mem_q[rptr_q[ad_w-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            dout_q <= dout_d;
        end
    end

    // Storage is deliberately not reset; reads are blocked until it has been written.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wptr_q[ad_w-1:0]] <= data_in;
        end
    end

    assign data_out = dout_q;

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo at default parameters (8-bit data, 16 entries).
module tb_fifo;

    logic       clk;
    logic       rst;
    logic       write;
    logic       read;
    logic       full;
    logic       empty;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int tests_run = 0;
    int tests_failed = 0;

    fifo #(.d_w(8), .ad_w(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .read     (read),
        .full     (full),
        .empty    (empty),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one set of requests across a rising edge, then settle for sampling.
    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        rst     = r;
        write   = w;
        read    = rd;
        data_in = d;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; read = 1'b0; data_in = '0;
        #1;

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_full", 32'(full), 32'd0);
        check("idle_dout", 32'(data_out), 32'd0);

        // Fill with 1..26; only 1..16 fit
        for (int i = 1; i <= 26; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
            check("fill_empty", 32'(empty), 32'd0);
            check("fill_full", 32'(full), (i >= 16) ? 32'd1 : 32'd0);
        end

        // Drain 16, one extra read while empty
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("drain_dout", 32'(data_out), 32'(i));
            check("drain_full", 32'(full), 32'd0);
            check("drain_empty", 32'(empty), (i == 16) ? 32'd1 : 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("underflow_dout", 32'(data_out), 32'd16);
        check("underflow_empty", 32'(empty), 32'd1);

        // Second lap: pointers wrap
        for (int i = 1; i <= 26; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(2 * i));
            check("wrap_fill_full", 32'(full), (i >= 16) ? 32'd1 : 32'd0);
        end
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("wrap_dout", 32'(data_out), 32'(2 * i));
        end
        check("wrap_empty", 32'(empty), 32'd1);
        check("wrap_full", 32'(full), 32'd0);

        // Simultaneous read/write with 3 stored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(100 + i));
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b1, 8'(103 + k));
            check("rw_dout", 32'(data_out), 32'(100 + k));
            check("rw_empty", 32'(empty), 32'd0);
            check("rw_full", 32'(full), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            check("rw_tail_dout", 32'(data_out), 32'(110 + k));
        end
        check("rw_tail_empty", 32'(empty), 32'd1);

        // Read+write while empty: only the write lands, no bypass
        step(1'b0, 1'b1, 1'b1, 8'd200);
        check("rw_empty_dout", 32'(data_out), 32'd112);
        check("rw_empty_flag", 32'(empty), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("rw_empty_pop", 32'(data_out), 32'd200);
        check("rw_empty_after", 32'(empty), 32'd1);

        // Mid-operation reset with 8 stored
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(50 + i));
        check("pre_rst_empty", 32'(empty), 32'd0);
        step(1'b1, 1'b1, 1'b1, 8'd99);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_dout", 32'(data_out), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        check("post_rst_dout", 32'(data_out), 32'd0);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
